// File: rtl/dac_sample_feeder_if.sv
// Request/response handshake between the DAC feeder (master) and a sample generator (slave).
interface dac_sample_feeder_if #(
    parameter int SAMPLE_W = 16
);
    logic                generate_next;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample;

    modport master (
        output generate_next,
        input  sample_ready,
        input  sample
    );

    modport slave (
        input  generate_next,
        output sample_ready,
        output sample
    );
endinterface

// File: rtl/dac_sample_feeder.sv
// Pulls one mono sample per audio frame and serializes it MSB-first on a left-justified DAC link.
// Optional build macro DAC_UNDERRUN_MUTE_EN: an underrun sends a silent frame and clears the held sample.
module dac_sample_feeder #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    dac_sample_feeder_if.master gen,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);
    localparam int H_N     = 4 * SAMPLE_W;
    localparam int H_W     = $clog2(H_N);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int FRAME_W = 2 * SAMPLE_W;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [H_W-1:0]      h_reg;
    logic [H_W-1:0]      h_next;
    logic [FRAME_W-1:0]  shreg_reg;
    logic [SAMPLE_W-1:0] hold_reg;
    logic                bclk_reg;
    logic                lrclk_reg;
    logic                generate_next_reg;
    logic                underrun_reg;
    logic                div_wrap;
    logic                fb;
    logic                miss;

    always_comb begin
        div_wrap = (div_reg == DIV_W'(CLK_DIV - 1));
        fb       = div_wrap && (h_reg == H_W'(H_N - 1));
        h_next   = h_reg;
        if (div_wrap) begin
            h_next = fb ? '0 : h_reg + 1'b1;
        end
        // A frame boundary reached while still waiting, with no data arriving in that cycle.
        miss = fb && (state_reg == WAIT) && !gen.sample_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= IDLE;
            div_reg           <= '0;
            h_reg             <= '0;
            shreg_reg         <= '0;
            hold_reg          <= '0;
            bclk_reg          <= 1'b0;
            lrclk_reg         <= 1'b0;
            generate_next_reg <= 1'b0;
            underrun_reg      <= 1'b0;
        end else begin
            div_reg           <= div_wrap ? '0 : div_reg + 1'b1;
            h_reg             <= h_next;
            bclk_reg          <= h_next[0];
            lrclk_reg         <= (h_next >= H_W'(FRAME_W));
            underrun_reg      <= miss;
            generate_next_reg <= 1'b0;

            // Shifting on the odd->even half-bit step puts data changes on bclk falling edges.
            if (fb) begin
`ifdef DAC_UNDERRUN_MUTE_EN
                shreg_reg <= miss ? '0 : {hold_reg, hold_reg};
`else
                shreg_reg <= {hold_reg, hold_reg};
`endif
            end else if (div_wrap && h_reg[0]) begin
                shreg_reg <= {shreg_reg[FRAME_W-2:0], 1'b0};
            end

            case (state_reg)
                IDLE: begin
                    if (fb) begin
                        state_reg         <= REQ;
                        generate_next_reg <= 1'b1;
                    end
                end
                REQ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (gen.sample_ready) begin
                        hold_reg  <= gen.sample;
                        state_reg <= IDLE;
                    end else if (fb) begin
                        state_reg         <= REQ;
                        generate_next_reg <= 1'b1;
`ifdef DAC_UNDERRUN_MUTE_EN
                        hold_reg          <= '0;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gen.generate_next = generate_next_reg;
    assign bclk              = bclk_reg;
    assign lrclk             = lrclk_reg;
    assign sdata             = shreg_reg[FRAME_W-1];
    assign underrun          = underrun_reg;
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Frame-by-frame directed test of dac_sample_feeder with CLK_DIV=2, SAMPLE_W=16 (128-cycle frames).
module tb_dac_sample_feeder;
    localparam int CLK_DIV  = 2;
    localparam int SAMPLE_W = 16;
    localparam int FRAME    = 4 * SAMPLE_W * CLK_DIV;

`ifdef DAC_UNDERRUN_MUTE_EN
    localparam logic [15:0] RPT = 16'h0000;
`else
    localparam logic [15:0] RPT = 16'h7FFF;
`endif

    typedef struct {
        bit          respond;      // answer the request pending at frame start
        logic [15:0] resp_val;
        int          inject_tick;  // extra sample_ready pulse after this tick, -1 = none
        logic [15:0] inject_val;
        logic [15:0] exp_word;     // sample expected on both channels this frame
        int          exp_req;      // generate_next pulses this frame, -1 = unchecked
        int          exp_under;
    } frame_t;

    logic clk;
    logic reset;
    logic bclk, lrclk, sdata, underrun;

    dac_sample_feeder_if #(.SAMPLE_W(SAMPLE_W)) gen_if ();

    dac_sample_feeder #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .gen      (gen_if),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit pending = 1'b0;
    frame_t tbl [13];
    frame_t extra [3];
    frame_t part;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input frame_t rec, input int idx, input int n_ticks);
        logic [31:0] word = '0;
        logic [31:0] lr   = '0;
        int nbits = 0, reqs = 0, unders = 0, bad_pos = 0;
        logic bclk_prev = bclk;
        for (int t = 0; t < n_ticks; t++) begin
            @(posedge clk);
            #1;
            if (bclk && !bclk_prev) begin
                word = {word[30:0], sdata};
                lr   = {lr[30:0], lrclk};
                nbits++;
                if ((t % 4) != 1) bad_pos++;
            end
            bclk_prev = bclk;
            gen_if.sample_ready = 1'b0;
            gen_if.sample       = 16'hDEAD;
            if (pending) begin
                pending = 1'b0;
                if (rec.respond) begin
                    gen_if.sample_ready = 1'b1;
                    gen_if.sample       = rec.resp_val;
                end
            end else if (t == rec.inject_tick) begin
                gen_if.sample_ready = 1'b1;
                gen_if.sample       = rec.inject_val;
            end
            if (gen_if.generate_next) begin
                reqs++;
                pending = 1'b1;
                if (t != FRAME - 1) bad_pos++;
            end
            if (underrun) begin
                unders++;
                if (t != FRAME - 1) bad_pos++;
            end
        end
        if (n_ticks == FRAME) begin
            $display("[TB] frame %0d: word=%h lr=%h req=%0d underrun=%0d", idx, word, lr, reqs, unders);
            check("bit_count", 32'(nbits), 32'd32);
            check("frame_word", word, {rec.exp_word, rec.exp_word});
            check("lrclk_pattern", lr, 32'h0000FFFF);
            if (rec.exp_req >= 0) check("request_count", 32'(reqs), 32'(rec.exp_req));
            check("underrun_count", 32'(unders), 32'(rec.exp_under));
            check("edge_timing", 32'(bad_pos), 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h0000, -1,  16'h0000, 16'h0000, 1, 0};
        tbl[1]  = '{1'b1, 16'hA5C3, -1,  16'h0000, 16'h0000, 1, 0};
        tbl[2]  = '{1'b1, 16'hA5C3, -1,  16'h0000, 16'hA5C3, 1, 0};
        tbl[3]  = '{1'b1, 16'h7FFF, -1,  16'h0000, 16'hA5C3, 1, 0};
        tbl[4]  = '{1'b0, 16'h0000, -1,  16'h0000, 16'h7FFF, 1, 1};
        tbl[5]  = '{1'b0, 16'h0000, -1,  16'h0000, RPT,      1, 1};
        tbl[6]  = '{1'b1, 16'h8000, -1,  16'h0000, RPT,      1, 0};
        tbl[7]  = '{1'b1, 16'h7FFF, -1,  16'h0000, 16'h8000, 1, 0};
        tbl[8]  = '{1'b1, 16'h8000, -1,  16'h0000, 16'h7FFF, 1, 0};
        tbl[9]  = '{1'b0, 16'h0000, 126, 16'h1234, 16'h8000, -1, 0};
        tbl[10] = '{1'b0, 16'h0000, 60,  16'hFFFF, 16'h8000, 1, 0};
        tbl[11] = '{1'b1, 16'h5A5A, 60,  16'hFFFF, 16'h1234, 1, 0};
        tbl[12] = '{1'b1, 16'hFFFF, -1,  16'h0000, 16'h5A5A, 1, 0};
        part    = '{1'b0, 16'h0000, -1,  16'h0000, 16'hFFFF, 1, 0};
        extra[0] = '{1'b0, 16'h0000, -1, 16'h0000, 16'h0000, 1, 0};
        extra[1] = '{1'b1, 16'h1111, -1, 16'h0000, 16'h0000, 1, 0};
        extra[2] = '{1'b1, 16'h2222, -1, 16'h0000, 16'h1111, 1, 0};

        reset               = 1'b0;
        gen_if.sample_ready = 1'b0;
        gen_if.sample       = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, bclk, lrclk, sdata, gen_if.generate_next, underrun}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_frame(tbl[i], i, FRAME);

        // Abort a frame mid-way while a request is outstanding and sdata is high.
        run_frame(part, 13, 40);
        check("pre_reset_sdata", {31'd0, sdata}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("[TB] reset cycle %0d", i);
            check("midframe_reset_outputs",
                  {27'd0, bclk, lrclk, sdata, gen_if.generate_next, underrun}, 32'd0);
        end
        reset   = 1'b1;
        pending = 1'b0;
        // A late answer to the dropped request lands in IDLE and must be ignored.
        gen_if.sample_ready = 1'b1;
        gen_if.sample       = 16'hBEEF;
        for (int i = 0; i < 3; i++) run_frame(extra[i], 14 + i, FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
